// File: rtl/pci_target_pkg.sv
// Shared definitions for the PCI-style memory target: bus command codes and FSM states.
package pci_target_pkg;

   localparam logic [3:0] CMD_SPECIAL   = 4'b0001;
   localparam logic [3:0] CMD_MEM_READ  = 4'b0110;
   localparam logic [3:0] CMD_MEM_WRITE = 4'b0111;

   typedef enum logic [2:0] {
      IDLE,
      BUS_BUSY,
      TURN,
      DATA,
      BACKOFF
   } state_t;

endpackage

// File: rtl/pci_target_mem.sv
// Word RAM with per-byte write enables, asynchronous read and asynchronous clear.
module pci_target_mem #(
   parameter int WORDS = 8,
   parameter int AW    = $clog2(WORDS)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          we,
   input  logic [3:0]    be,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem_q [WORDS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < WORDS; i++) mem_q[i] <= '0;
      end else if (we) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) mem_q[addr][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

   assign rdata = mem_q[addr];

endmodule

// File: rtl/pci_target_core.sv
// PCI-style memory target: window decode, DEVSEL/TRDY handshake, burst transfers and
// disconnect when a burst runs off the end of the window.
module pci_target_core
   import pci_target_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          MEM_WORDS = 8
) (
   input  logic        clk,
   input  logic        reset,
   output logic        stop,
   inout  wire  [31:0] Address_Data,
   input  logic        NFRAME,
   input  logic        NIRED,
   input  logic [3:0]  C_BE,
   output logic        NTRED,
   output logic        NDEVSEL
);

   localparam int IDX_W   = $clog2(MEM_WORDS);
   localparam int WIN_LSB = IDX_W + 2;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             wr_q, wr_d;
   logic             ndevsel_q, ndevsel_d;
   logic             ntrdy_q, ntrdy_d;
   logic             stop_q, stop_d;
   logic             oe_q, oe_d;
   logic             hit, xfer, last_word, mem_we;
   logic [31:0]      rdata;

   // Handshake: a data word moves on a rising edge where both NIRED and NTRED are low;
   // either side holding its ready high stalls the phase with everything else unchanged.
   assign xfer      = (state_q == DATA) && !ntrdy_q && !NIRED;
   assign last_word = (idx_q == IDX_W'(MEM_WORDS - 1));
   assign hit       = (Address_Data[31:WIN_LSB] == BASE_ADDR[31:WIN_LSB]);
   assign mem_we    = xfer && wr_q;

   pci_target_mem #(.WORDS(MEM_WORDS)) u_mem (
      .clk   (clk),
      .rst_n (reset),
      .we    (mem_we),
      .be    (C_BE),
      .addr  (idx_q),
      .wdata (Address_Data),
      .rdata (rdata)
   );

   assign Address_Data = oe_q ? rdata : 'z;
   assign NDEVSEL      = ndevsel_q;
   assign NTRED        = ntrdy_q;
   assign stop         = stop_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         wr_q      <= 1'b0;
         ndevsel_q <= 1'b1;
         ntrdy_q   <= 1'b1;
         stop_q    <= 1'b0;
         oe_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         wr_q      <= wr_d;
         ndevsel_q <= ndevsel_d;
         ntrdy_q   <= ntrdy_d;
         stop_q    <= stop_d;
         oe_q      <= oe_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      wr_d      = wr_q;
      ndevsel_d = ndevsel_q;
      ntrdy_d   = ntrdy_q;
      stop_d    = stop_q;
      oe_d      = oe_q;
      case (state_q)
         IDLE: begin
            if (!NFRAME) begin
               idx_d = Address_Data[WIN_LSB-1:2];
               if (hit && C_BE == CMD_MEM_WRITE) begin
                  wr_d      = 1'b1;
                  ndevsel_d = 1'b0;
                  ntrdy_d   = 1'b0;
                  state_d   = DATA;
               end else if (hit && C_BE == CMD_MEM_READ) begin
                  wr_d      = 1'b0;
                  ndevsel_d = 1'b0;
                  state_d   = TURN;
               end else begin
                  state_d = BUS_BUSY;
               end
            end
         end
         BUS_BUSY: begin
            if (NFRAME && NIRED) state_d = IDLE;
         end
         TURN: begin
            ntrdy_d = 1'b0;
            oe_d    = 1'b1;
            state_d = DATA;
         end
         DATA: begin
            if (xfer) begin
               if (NFRAME) begin
                  ndevsel_d = 1'b1;
                  ntrdy_d   = 1'b1;
                  oe_d      = 1'b0;
                  state_d   = IDLE;
               end else if (last_word) begin
                  // Burst would leave the window: disconnect instead of wrapping.
                  stop_d  = 1'b1;
                  ntrdy_d = 1'b1;
                  oe_d    = 1'b0;
                  state_d = BACKOFF;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         BACKOFF: begin
            if (NFRAME) begin
               ndevsel_d = 1'b1;
               stop_d    = 1'b0;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_pci_target_core.sv
// Directed bench for pci_target_core: transaction-level model predicts per-cycle bus outputs.
module tb_pci_target_core;
   import pci_target_pkg::*;

   localparam logic [31:0] BASE  = 32'h0000_0000;
   localparam int          WORDS = 8;
   localparam logic [31:0] WIN   = 32'd32;
   localparam logic [31:0] BUS_RELEASED = 32'hFFFF_FFFF;
   localparam logic [35:0] IDLE_EXP = {1'b1, 1'b1, 1'b0, 1'b0, 32'h0};

   logic        clk;
   logic        reset;
   logic        stop;
   wire  [31:0] ad_bus;
   logic        nframe;
   logic        nired;
   logic [3:0]  cbe;
   logic        ntred;
   logic        ndevsel;

   logic        tb_oe;
   logic [31:0] tb_ad;

   // A released bus reads as all ones.
   pullup (ad_bus);
   assign ad_bus = tb_oe ? tb_ad : 'z;

   pci_target_core #(.BASE_ADDR(BASE), .MEM_WORDS(WORDS)) dut (
      .clk          (clk),
      .reset        (reset),
      .stop         (stop),
      .Address_Data (ad_bus),
      .NFRAME       (nframe),
      .NIRED        (nired),
      .C_BE         (cbe),
      .NTRED        (ntred),
      .NDEVSEL      (ndevsel)
   );

   // ---------------- clock / watchdog ----------------
   initial begin
      clk = 1'b0;
      forever #10 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // ---------------- scoreboard state ----------------
   int          checks;
   int          failures;
   logic        chk_en;
   logic [35:0] exp_q[$];
   logic [35:0] cur_exp;
   logic [35:0] cmp_e;
   logic [31:0] rd_q[$];
   logic [31:0] model_mem [WORDS];
   logic [31:0] wdat [16];
   logic [3:0]  wbe  [16];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [35:0] mk(input logic dev_n, input logic trdy_n, input logic stp,
                                      input logic drv, input logic [31:0] d);
      return {dev_n, trdy_n, stp, drv, d};
   endfunction

   function automatic logic [31:0] be_merge(input logic [31:0] old, input logic [31:0] nw,
                                            input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
      return r;
   endfunction

   // Compare process: outputs after each edge against the model's prediction.
   always @(negedge clk) begin
      if (chk_en && exp_q.size() != 0) begin
         cmp_e = exp_q.pop_front();
         check("ctrl{devsel_n,trdy_n,stop}", {29'd0, ndevsel, ntred, stop}, {29'd0, cmp_e[35:33]});
         check("ad_bus", ad_bus, tb_oe ? tb_ad : (cmp_e[32] ? cmp_e[31:0] : BUS_RELEASED));
      end
   end

   // Read-data capture: words on the bus at edges where a read transfer happens.
   always @(negedge clk) begin
      if (chk_en && !ntred && !nired && !tb_oe) rd_q.push_back(ad_bus);
   end

   // ---------------- driver tasks ----------------
   task automatic step(input logic f, input logic i, input logic [3:0] be,
                       input logic oe, input logic [31:0] ad);
      @(posedge clk);
      #2;
      exp_q.push_back(cur_exp);
      nframe = f;
      nired  = i;
      cbe    = be;
      tb_oe  = oe;
      tb_ad  = ad;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(1'b1, 1'b1, 4'h0, 1'b0, 32'h0);
   endtask

   // One initiator transaction of n data phases; wait_len idle phases before phase wait_at.
   task automatic run_txn(input logic [31:0] addr, input logic [3:0] cmd, input int n,
                          input int wait_at, input int wait_len);
      bit hit, rd, stopped;
      int idx;
      hit = (cmd == CMD_MEM_READ || cmd == CMD_MEM_WRITE) && addr >= BASE && addr < BASE + WIN;
      rd  = (cmd == CMD_MEM_READ);
      idx = int'((addr - BASE) >> 2);
      step(1'b0, 1'b1, cmd, 1'b1, addr);
      if (!hit) begin
         cur_exp = IDLE_EXP;
         for (int k = 0; k < n; k++) step(k == n - 1, 1'b0, wbe[k], !rd, wdat[k]);
         step(1'b1, 1'b1, 4'h0, 1'b0, 32'h0);
         return;
      end
      cur_exp = mk(1'b0, rd, 1'b0, 1'b0, 32'h0);
      if (rd) begin
         step(n == 1, 1'b0, 4'hF, 1'b0, 32'h0);
         cur_exp = mk(1'b0, 1'b0, 1'b0, 1'b1, model_mem[idx]);
      end
      stopped = 0;
      for (int k = 0; k < n && !stopped; k++) begin
         if (k == wait_at) begin
            for (int w = 0; w < wait_len; w++) step(1'b0, 1'b1, 4'hF, !rd, 32'h0BAD_0BAD);
         end
         step(k == n - 1, 1'b0, rd ? 4'hF : wbe[k], !rd, wdat[k]);
         if (!rd) model_mem[idx] = be_merge(model_mem[idx], wdat[k], wbe[k]);
         if (k == n - 1) begin
            cur_exp = IDLE_EXP;
         end else if (idx == WORDS - 1) begin
            cur_exp = mk(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
            stopped = 1;
         end else begin
            idx++;
            cur_exp = mk(1'b0, 1'b0, 1'b0, rd, rd ? model_mem[idx] : 32'h0);
         end
      end
      if (stopped) begin
         // Initiator keeps FRAME low one more phase before honouring the disconnect.
         step(1'b0, 1'b0, 4'hF, !rd, 32'h0BAD_0BAD);
         step(1'b1, 1'b1, 4'h0, 1'b0, 32'h0);
         cur_exp = IDLE_EXP;
      end
   endtask

   task automatic check_rd(input string name, input int k, input logic [31:0] v);
      if (k < rd_q.size()) check(name, rd_q[k], v);
      else check(name, 32'hDEAD_0000 | 32'(rd_q.size()), v);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      checks = 0; failures = 0;
      reset = 1'b0; nframe = 1'b1; nired = 1'b1; cbe = 4'h0;
      tb_oe = 1'b0; tb_ad = 32'h0; chk_en = 1'b0; cur_exp = IDLE_EXP;
      for (int i = 0; i < WORDS; i++) model_mem[i] = 32'h0;
      for (int i = 0; i < 16; i++) begin wdat[i] = 32'h0; wbe[i] = 4'hF; end

      #35;
      check("reset_ctrl", {29'd0, ndevsel, ntred, stop}, 32'd6);
      check("reset_ad", ad_bus, BUS_RELEASED);
      #5 reset = 1'b1;
      chk_en = 1'b1;
      idle(2);

      // Special cycle: ten data phases, target must stay silent.
      run_txn(32'h1111_1111, CMD_SPECIAL, 10, -1, 0);
      idle(1);

      // Single write then single read at BASE+4.
      wdat[0] = 32'hDEAD_BEEF; wbe[0] = 4'hF;
      run_txn(BASE + 4, CMD_MEM_WRITE, 1, -1, 0);
      rd_q.delete();
      run_txn(BASE + 4, CMD_MEM_READ, 1, -1, 0);
      idle(1);
      check("single_rd_count", 32'(rd_q.size()), 32'd1);
      check_rd("single_rd", 0, 32'hDEAD_BEEF);
      check("model_pin_word1", model_mem[1], 32'hDEAD_BEEF);

      // Burst write of 4 words with an initiator wait mid-burst, then burst read with a wait.
      wdat[0] = 32'hA000_0001; wdat[1] = 32'hB000_0002;
      wdat[2] = 32'hC000_0003; wdat[3] = 32'hD000_0004;
      for (int i = 0; i < 4; i++) wbe[i] = 4'hF;
      run_txn(BASE, CMD_MEM_WRITE, 4, 2, 2);
      rd_q.delete();
      run_txn(BASE, CMD_MEM_READ, 4, 1, 2);
      idle(1);
      check("burst_rd_count", 32'(rd_q.size()), 32'd4);
      check_rd("burst_rd0", 0, 32'hA000_0001);
      check_rd("burst_rd1", 1, 32'hB000_0002);
      check_rd("burst_rd2", 2, 32'hC000_0003);
      check_rd("burst_rd3", 3, 32'hD000_0004);

      // Partial byte-enable write over all ones.
      wdat[0] = 32'hFFFF_FFFF; wbe[0] = 4'hF;
      run_txn(BASE + 16, CMD_MEM_WRITE, 1, -1, 0);
      wdat[0] = 32'hAAAA_5555; wbe[0] = 4'b0011;
      run_txn(BASE + 16, CMD_MEM_WRITE, 1, -1, 0);
      rd_q.delete();
      run_txn(BASE + 16, CMD_MEM_READ, 1, -1, 0);
      idle(1);
      check_rd("be_merge_rd", 0, 32'hFFFF_5555);

      // Misses just past the window.
      wdat[0] = 32'h1234_5678; wbe[0] = 4'hF;
      run_txn(BASE + WIN, CMD_MEM_WRITE, 1, -1, 0);
      run_txn(BASE + WIN, CMD_MEM_READ, 2, -1, 0);
      idle(1);

      // Bursts from BASE+24 that run into the window end.
      wdat[0] = 32'h6666_0006; wdat[1] = 32'h7777_0007; wdat[2] = 32'h0BAD_0BAD;
      for (int i = 0; i < 3; i++) wbe[i] = 4'hF;
      run_txn(BASE + 24, CMD_MEM_WRITE, 3, -1, 0);
      rd_q.delete();
      run_txn(BASE + 24, CMD_MEM_READ, 3, -1, 0);
      idle(1);
      check("stop_rd_count", 32'(rd_q.size()), 32'd2);
      check_rd("stop_rd0", 0, 32'h6666_0006);
      check_rd("stop_rd1", 1, 32'h7777_0007);
      rd_q.delete();
      run_txn(BASE + 24, CMD_MEM_READ, 2, -1, 0);
      run_txn(BASE, CMD_MEM_READ, 1, -1, 0);
      idle(1);
      check("lastword_rd_count", 32'(rd_q.size()), 32'd3);
      check_rd("lastword_rd7", 1, 32'h7777_0007);
      check_rd("no_wrap_word0", 2, 32'hA000_0001);

      // Reset in the middle of a write data phase.
      step(1'b0, 1'b1, CMD_MEM_WRITE, 1'b1, BASE + 8);
      cur_exp = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      step(1'b1, 1'b0, 4'hF, 1'b1, 32'h5A5A_5A5A);
      @(negedge clk);
      chk_en = 1'b0;
      #1 reset = 1'b0;
      #1;
      check("midreset_ctrl", {29'd0, ndevsel, ntred, stop}, 32'd6);
      exp_q.delete();
      nframe = 1'b1; nired = 1'b1; tb_oe = 1'b0; cbe = 4'h0;
      #20 reset = 1'b1;
      for (int i = 0; i < WORDS; i++) model_mem[i] = 32'h0;
      cur_exp = IDLE_EXP;
      chk_en = 1'b1;
      idle(1);
      rd_q.delete();
      run_txn(BASE, CMD_MEM_READ, 8, -1, 0);
      idle(2);
      check("cleared_rd_count", 32'(rd_q.size()), 32'd8);
      for (int i = 0; i < WORDS; i++) check_rd("cleared_word", i, 32'h0);

      @(negedge clk);
      #1;
      check("exp_q_drained", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pci_target_core.md
Name: pci_target_core

Overview:
- 32-bit PCI-style bus target with a small internal word memory.
- Decodes memory read/write commands to its address window and handshakes with NDEVSEL/NTRED.
- Sources read data onto the shared Address_Data bus and ignores special cycles.
- Sits on the multiplexed AD/C_BE bus beside an initiator; the free-running clk comes from the separate simulation clock generator (20 ns period), which is not part of this block.

Parameters:
- BASE_ADDR, 32'h0000_0000: window base address, aligned to the window size.
- MEM_WORDS, 8: number of 32-bit memory words (power of two). Window size is MEM_WORDS*4 bytes.

Ports:
- clk  in  1  bus clock; all sampling on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- stop  out  1  active-high target-disconnect request.
- Address_Data  inout  32  multiplexed address/data bus. Driven only during read data phases, otherwise high-Z.
- NFRAME  in  1  active-low FRAME#.
- NIRED  in  1  active-low initiator ready (IRDY#).
- C_BE  in  4  command during the address phase; byte enables during data phases (active-high, bit i enables byte lane i).
- NTRED  out  1  active-low target ready (TRDY#).
- NDEVSEL  out  1  active-low device select.

Behaviour:
Reset (reset low, async):
- state IDLE; NDEVSEL=1, NTRED=1, stop=0; AD output enable off; memory cleared to 0.

Commands:
- 4'b0110 memory read, 4'b0111 memory write, 4'b0001 special cycle. All others are ignored.

Address phase:
- A rising edge in IDLE with NFRAME=0 is the address phase. Latch Address_Data and C_BE.
- Hit = read/write command AND addr[31:log2(MEM_WORDS*4)] == BASE_ADDR upper bits. Word index = addr bits above [1:0].

States: IDLE, BUS_BUSY, TURN (read turnaround), DATA, BACKOFF.
- Miss, special cycle or ignored command -> BUS_BUSY. Outputs stay deasserted; return to IDLE on the first edge with NFRAME=1 and NIRED=1.
- Write hit:
  - At the address-phase edge register NDEVSEL=0 and NTRED=0 (zero wait states) -> DATA.
- Read hit:
  - At the address-phase edge register NDEVSEL=0 and go to TURN.
  - Next edge: drive mem[index] on AD with NTRED=0 -> DATA.

DATA:
- A transfer occurs at each edge with NIRED=0 and NTRED=0.
  - Write: byte lanes with C_BE bit set are written.
  - Read: AD is updated to the next word after each transfer.
- After each transfer the index increments by 1.
- NIRED=1 is an initiator wait: no transfer, no address change, outputs held.
- Final transfer is the edge with NFRAME=1 and NIRED=0: deassert NDEVSEL and NTRED, release AD, -> IDLE.

Disconnect:
- If a transfer completes on the last word and NFRAME is still 0, assert stop=1, NTRED=1, keep NDEVSEL=0 and release AD -> BACKOFF.
- BACKOFF: hold until an edge with NFRAME=1, then NDEVSEL=1, stop=0 -> IDLE.
- The index never wraps.

Other rules:
- Special cycle, e.g. address-phase value 32'h11111111 with C_BE 0001: never asserts NDEVSEL/NTRED/stop and never drives AD; memory untouched.
- Reset mid-transaction aborts immediately to reset values; no partial write completes.
- Simultaneous NFRAME rising and a last-word transfer: a normal completion, no stop.

Decomposition:
- Package pci_target_pkg: command constants (CMD_SPECIAL=4'b0001, CMD_MEM_READ=4'b0110, CMD_MEM_WRITE=4'b0111) and the state enum.
- One sub-module is natural: pci_target_mem, a byte-enable-writable word RAM with async clear.
- Decoder, FSM and tri-state AD driver live in the top.

Test Plan:
- Reset pulse low 40 ns -> NDEVSEL=1, NTRED=1, stop=0, AD high-Z.
- Special cycle: NFRAME=0, AD=32'h11111111, C_BE=0001, then data 32'h0 with BE 1111, NIRED=0 for 200 ns -> NDEVSEL/NTRED stay 1, AD never driven by target.
- Single write of 32'hDEADBEEF to BASE+4 with BE 1111, then single read of BASE+4 -> DEVSEL one cycle after address, TRDY one cycle later, AD=32'hDEADBEEF.
- Burst write of 4 words at BASE with NIRED high for 2 cycles mid-burst, then burst read -> the 4 words are read back in order; no transfer during the waits.
- Write with BE 0011 of 32'hAAAA5555 over 32'hFFFFFFFF -> readback 32'hFFFF5555.
- Miss (address BASE+32 with MEM_WORDS=8) -> no NDEVSEL.
- Burst from BASE+24 held 3 phases -> 2 transfers, stop=1 after the last word, release after NFRAME=1.
